rr_merge: RTL and testbench
===========================

RR_MERGE -- requirements
Module: rr_merge

Interface
REQ-001 Parameter N_MASTERS, default 2: number of requesting masters; legal range 2..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Derived widths: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, packed {valid, addr, wdata, wstrb}, valid at MSB. RESP_W = DATA_W+1, packed {rdata, ready}, ready at LSB. N_W = clog2(N_MASTERS).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 m_req  input  N_MASTERS*REQ_W  master requests; master i occupies slice i.
REQ-008 m_resp  output  N_MASTERS*RESP_W  master responses; master i occupies slice i.
REQ-009 s_req  output  REQ_W  request to the shared slave.
REQ-010 s_resp  input  RESP_W  response from the shared slave.
REQ-011 grant  output  N_W  index of the master currently or last granted.
REQ-012 busy  output  1  high while a transaction is in flight (state BUSY).

Function
REQ-013 The block SHALL implement two states: IDLE and BUSY.
REQ-014 In IDLE, s_req SHALL be all-zero, and every m_resp slice SHALL be all-zero.
REQ-015 In IDLE, if any master valid is high, the block SHALL register the winner into grant and enter BUSY on the next edge.
- Winner = first valid master searching upward from (last+1) mod N_MASTERS, wrapping.
- last = index of the last completed grant.
REQ-016 In IDLE with no valid master, the block SHALL hold state, grant and last.
REQ-017 In BUSY, s_req SHALL equal m_req slice [grant] combinationally.
REQ-018 In BUSY, m_resp slice [grant] SHALL equal s_resp, and all other slices SHALL be zero.
REQ-019 In BUSY, when s_resp.ready=1, the block SHALL set last=grant and return to IDLE on the next edge; the transaction completes in that cycle.
REQ-020 In BUSY, if the granted master's valid is 0 and s_resp.ready=0, the block SHALL abort: return to IDLE next edge with last unchanged.
REQ-021 Minimum latency: master valid to slave valid is 1 cycle. Back-to-back transactions are separated by at least one IDLE cycle.
REQ-022 Requests arriving while BUSY SHALL wait; they are not lost provided the masters hold valid (masters hold valid until ready).
REQ-023 Fairness: with all masters continuously requesting, grants SHALL rotate 0,1,...,N_MASTERS-1,0,...; no master waits more than N_MASTERS-1 transactions.
REQ-024 If a non-power-of-two N_MASTERS is used, wrap-around SHALL skip unused indices.
REQ-025 busy SHALL be 1 exactly when state is BUSY.

Reset
REQ-026 While rst=0: state=IDLE, grant=0, busy=0, s_req=0, m_resp=0.
REQ-027 While rst=0: last=N_MASTERS-1, so the first arbitration favours master 0.
REQ-028 Reset asserted mid-transaction SHALL immediately drop s_req.valid and m_resp to zero, with no completion recorded.

Verification
REQ-029 N=2, master 1 valid alone, slave ready 2 cycles after s_req.valid -> grant=1, busy high for 3 cycles, m_resp[1] carries rdata with ready=1, m_resp[0]=0.
REQ-030 N=4, all masters valid continuously, slave ready in 1 cycle -> grant sequence 0,1,2,3,0 over 10 cycles.
REQ-031 N=4, masters 0 and 2 valid after master 2 just completed -> grant=0 next; then grant=2.
REQ-032 N=3, masters 0 and 2 valid, last=2 -> grant=0; then grant=2 (index 3 never produced).
REQ-033 Granted master drops valid before ready -> IDLE next cycle, last unchanged, and the same master regains priority.
REQ-034 rst pulsed low while BUSY -> s_req=0, busy=0 asynchronously; after release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/rr_merge.sv
// Round-robin merge of N_MASTERS request/response channels onto one shared slave port.
// One transaction in flight at a time; an IDLE cycle separates consecutive grants.
module rr_merge #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int unsigned RESP_W   = DATA_W + 1,
    localparam int unsigned N_W      = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_W-1:0]                grant,
    output logic                          busy
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q;
    logic [N_W-1:0]     grant_q;
    logic [N_W-1:0]     last_q;
    logic [N_W-1:0]     winner;
    logic               any_valid;
    logic [N_MASTERS-1:0] vld;
    logic [REQ_W-1:0]   sel_req;

    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            vld[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Search upward from last+1, wrapping modulo N_MASTERS so unused indices never win.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            idx = (32'(last_q) + k) % N_MASTERS;
            if (!any_valid && vld[N_W'(idx)]) begin
                any_valid = 1'b1;
                winner    = N_W'(idx);
            end
        end
    end

    assign sel_req = m_req[32'(grant_q)*REQ_W +: REQ_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= N_W'(N_MASTERS - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        grant_q <= winner;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (s_resp[0]) begin
                        last_q  <= grant_q;
                        state_q <= StIdle;
                    end else if (!sel_req[REQ_W-1]) begin
                        // Master withdrew before completion: abort without moving priority.
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (state_q == StBusy) begin
            s_req = sel_req;
            m_resp[32'(grant_q)*RESP_W +: RESP_W] = s_resp;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == StBusy);

endmodule

// File: tb/tb_rr_merge.sv
// Scoreboard bench for rr_merge: N=4, N=3 and N=2 instances share stimulus; one is observed
// at a time and every completion is matched against the expected grant order.
module tb_rr_merge;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4*REQ_W-1:0]  m_req_all;
    logic [RESP_W-1:0]   s_resp;

    logic [4*RESP_W-1:0] m_resp4;
    logic [REQ_W-1:0]    s_req4;
    logic [1:0]          grant4;
    logic                busy4;
    logic [3*RESP_W-1:0] m_resp3;
    logic [REQ_W-1:0]    s_req3;
    logic [1:0]          grant3;
    logic                busy3;
    logic [2*RESP_W-1:0] m_resp2;
    logic [REQ_W-1:0]    s_req2;
    logic [0:0]          grant2;
    logic                busy2;

    rr_merge #(.N_MASTERS(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut4 (
        .clk(clk), .rst(rst), .m_req(m_req_all), .m_resp(m_resp4),
        .s_req(s_req4), .s_resp(s_resp), .grant(grant4), .busy(busy4)
    );
    rr_merge #(.N_MASTERS(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut3 (
        .clk(clk), .rst(rst), .m_req(m_req_all[3*REQ_W-1:0]), .m_resp(m_resp3),
        .s_req(s_req3), .s_resp(s_resp), .grant(grant3), .busy(busy3)
    );
    rr_merge #(.N_MASTERS(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut2 (
        .clk(clk), .rst(rst), .m_req(m_req_all[2*REQ_W-1:0]), .m_resp(m_resp2),
        .s_req(s_req2), .s_resp(s_resp), .grant(grant2), .busy(busy2)
    );

    logic                  valid_m [4];
    logic                  one_shot[4];
    logic [ADDR_W-1:0]     addr_m  [4];
    logic [DATA_W-1:0]     wdata_m [4];
    logic [DATA_W/8-1:0]   wstrb_m [4];

    always_comb begin
        m_req_all = '0;
        for (int i = 0; i < 4; i++) begin
            m_req_all[i*REQ_W +: REQ_W] = {valid_m[i], addr_m[i], wdata_m[i], wstrb_m[i]};
        end
    end

    int                  n_sel;
    logic                obs_busy;
    logic [1:0]          obs_grant;
    logic [REQ_W-1:0]    obs_s_req;
    logic [4*RESP_W-1:0] obs_m_resp;

    always_comb begin
        obs_busy   = busy4;
        obs_grant  = grant4;
        obs_s_req  = s_req4;
        obs_m_resp = m_resp4;
        if (n_sel == 3) begin
            obs_busy   = busy3;
            obs_grant  = grant3;
            obs_s_req  = s_req3;
            obs_m_resp = '0;
            obs_m_resp[3*RESP_W-1:0] = m_resp3;
        end else if (n_sel == 2) begin
            obs_busy   = busy2;
            obs_grant  = {1'b0, grant2};
            obs_s_req  = s_req2;
            obs_m_resp = '0;
            obs_m_resp[2*RESP_W-1:0] = m_resp2;
        end
    end

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b0;
        n_sel  = n;
        s_resp = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            valid_m[i]  = 1'b0;
            one_shot[i] = 1'b0;
            addr_m[i]   = ADDR_W'($urandom);
            wdata_m[i]  = DATA_W'($urandom);
            wstrb_m[i]  = (DATA_W/8)'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Slave model plus checker: ready after `lat` busy cycles; granted master drops valid at
    // busy cycle `drop_at`. Returns after the scoreboard drains on a completion/abort.
    task automatic run(input int n, input int budget, input int lat, input int drop_at);
        int   bcnt = 0;
        int   g;
        int   e;
        bit   prev_known = 0;
        bit   prev_busy = 0;
        bit   prev_anyv = 0;
        bit   just_done = 0;
        bit   done = 0;
        logic [REQ_W-1:0]  exp_req;
        logic [RESP_W-1:0] exp_slice;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (just_done) begin
                tests++;
                if (obs_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_gap: busy=%b want 0 (N=%0d)", obs_busy, n);
                end
            end else if (prev_known && !prev_busy) begin
                tests++;
                if (obs_busy !== prev_anyv) begin
                    fails++;
                    $display("FAIL grant_latency: busy=%b want %b (N=%0d)", obs_busy, prev_anyv, n);
                end
            end
            just_done = 0;
            g = int'(obs_grant);
            if (obs_busy === 1'b1) begin
                tests++;
                if (g >= n) begin
                    fails++;
                    $display("FAIL grant_range: grant=%0d want <%0d", g, n);
                end
                if (bcnt == drop_at && g < n) valid_m[g] = 1'b0;
                s_resp = {DATA_W'($urandom), (bcnt == lat)};
            end else begin
                s_resp = RESP_W'($urandom);
            end
            #1;
            exp_req = '0;
            if (obs_busy === 1'b1 && g < n)
                exp_req = {valid_m[g], addr_m[g], wdata_m[g], wstrb_m[g]};
            tests++;
            if (obs_s_req !== exp_req) begin
                fails++;
                $display("FAIL s_req: got %h want %h (busy=%b grant=%0d)", obs_s_req, exp_req,
                         obs_busy, g);
            end
            for (int j = 0; j < 4; j++) begin
                exp_slice = (obs_busy === 1'b1 && j == g) ? s_resp : '0;
                tests++;
                if (obs_m_resp[j*RESP_W +: RESP_W] !== exp_slice) begin
                    fails++;
                    $display("FAIL m_resp[%0d]: got %h want %h", j,
                             obs_m_resp[j*RESP_W +: RESP_W], exp_slice);
                end
            end
            if (obs_busy === 1'b1) begin
                if (s_resp[0]) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL grant_order: got completion for %0d want none", g);
                    end else begin
                        e = exp_q.pop_front();
                        if (g != e) begin
                            fails++;
                            $display("FAIL grant_order: got %0d want %0d (N=%0d)", g, e, n);
                        end
                    end
                    if (g < n && one_shot[g]) valid_m[g] = 1'b0;
                    just_done = 1;
                    bcnt = 0;
                    if (exp_q.size() == 0) done = 1;
                end else if (g >= n || !valid_m[g]) begin
                    just_done = 1;
                    bcnt = 0;
                    if (exp_q.size() == 0) done = 1;
                end else begin
                    bcnt++;
                end
            end
            prev_known = 1;
            prev_busy  = (obs_busy === 1'b1);
            prev_anyv  = 0;
            for (int j = 0; j < n; j++) if (valid_m[j]) prev_anyv = 1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL timeout: %0d grants outstanding after %0d cycles want 0 (N=%0d)",
                     exp_q.size(), budget, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b0;
        n_sel = 4;
        for (int i = 0; i < 4; i++) valid_m[i] = 1'b1;
        s_resp = {DATA_W'(16'hA5A5), 1'b1};
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (obs_busy !== 1'b0 || obs_grant !== 2'd0) begin
                fails++;
                $display("FAIL reset_state: busy=%b grant=%0d want 0/0", obs_busy, obs_grant);
            end
            tests++;
            if (obs_s_req !== '0 || obs_m_resp !== '0) begin
                fails++;
                $display("FAIL reset_outputs: s_req=%h m_resp=%h want 0", obs_s_req, obs_m_resp);
            end
        end
        do_reset(4);
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (obs_busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_hold: busy=%b want 0", obs_busy);
            end
        end
    endtask

    task automatic test_single_n2();
        do_reset(2);
        valid_m[1] = 1'b1;
        one_shot[1] = 1'b1;
        exp_q.push_back(1);
        run(2, 20, 2, -1);
    endtask

    task automatic test_rotation_n4();
        do_reset(4);
        for (int i = 0; i < 4; i++) valid_m[i] = 1'b1;
        exp_q = '{0, 1, 2, 3, 0};
        run(4, 10, 0, -1);
    endtask

    task automatic test_after_master2();
        do_reset(4);
        valid_m[2] = 1'b1;
        one_shot[2] = 1'b1;
        exp_q.push_back(2);
        run(4, 20, 1, -1);
        valid_m[0] = 1'b1;
        valid_m[2] = 1'b1;
        one_shot[0] = 1'b1;
        exp_q = '{0, 2};
        run(4, 30, 1, -1);
    endtask

    task automatic test_wrap_n3();
        do_reset(3);
        valid_m[0] = 1'b1;
        valid_m[2] = 1'b1;
        for (int i = 0; i < 3; i++) one_shot[i] = 1'b1;
        exp_q = '{0, 2};
        run(3, 30, 0, -1);
        valid_m[0] = 1'b1;
        valid_m[1] = 1'b1;
        exp_q = '{0, 1};
        run(3, 30, 2, -1);
    endtask

    task automatic test_abort();
        do_reset(4);
        valid_m[1] = 1'b1;
        one_shot[1] = 1'b1;
        exp_q.push_back(1);
        run(4, 20, 0, -1);
        valid_m[3] = 1'b1;
        run(4, 20, 100, 1);
        @(negedge clk);
        tests++;
        if (obs_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b want 0", obs_busy);
        end
        // last must still be 1, so 3 outranks 0
        valid_m[0] = 1'b1;
        valid_m[3] = 1'b1;
        one_shot[0] = 1'b1;
        one_shot[3] = 1'b1;
        exp_q = '{3, 0};
        run(4, 30, 1, -1);
    endtask

    task automatic test_reset_mid();
        do_reset(4);
        valid_m[2] = 1'b1;
        valid_m[3] = 1'b1;
        @(negedge clk);
        tests++;
        if (obs_busy !== 1'b1 || obs_grant !== 2'd2) begin
            fails++;
            $display("FAIL mid_setup: busy=%b grant=%0d want 1/2", obs_busy, obs_grant);
        end
        s_resp = {DATA_W'(16'hBEEF), 1'b0};
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (obs_busy !== 1'b0 || obs_grant !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: busy=%b grant=%0d want 0/0", obs_busy, obs_grant);
        end
        tests++;
        if (obs_s_req !== '0 || obs_m_resp !== '0) begin
            fails++;
            $display("FAIL async_reset_out: s_req=%h m_resp=%h want 0", obs_s_req, obs_m_resp);
        end
        @(negedge clk);
        rst = 1'b1;
        s_resp = '0;
        valid_m[1] = 1'b1;
        for (int i = 1; i < 4; i++) one_shot[i] = 1'b1;
        exp_q = '{1, 2, 3};
        run(4, 40, 1, -1);
    endtask

    initial begin
        rst   = 1'b0;
        n_sel = 4;
        s_resp = '0;
        for (int i = 0; i < 4; i++) begin
            valid_m[i]  = 1'b0;
            one_shot[i] = 1'b0;
            addr_m[i]   = '0;
            wdata_m[i]  = '0;
            wstrb_m[i]  = '0;
        end
        test_reset();
        test_single_n2();
        test_rotation_n4();
        test_after_master2();
        test_wrap_n3();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
